local_injector: RTL and testbench

LOCAL_INJECTOR -- requirements
Module: local_injector

---
 rtl/local_injector_pkg.sv | 17 +
 rtl/local_injector_if.sv | 31 +++
 rtl/local_injector_packet_fifo.sv | 63 ++++++
 rtl/local_injector.sv | 120 ++++++++++++
 tb/tb_local_injector.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/local_injector_pkg.sv
// Shared constants and FSM encoding for the local injector: packet/flit
// geometry, default buffer depth and the serializer state type.
package local_injector_pkg;

  localparam int LI_PACKET_SIZE      = 32;
  localparam int LI_FLIT_WIDTH       = 4;
  localparam int LI_FLITS_PER_PACKET = LI_PACKET_SIZE / LI_FLIT_WIDTH;
  localparam int LI_FIFO_DEPTH       = 4;
  localparam int LI_DROP_WIDTH       = 8;

  // Serializer states: IDLE waits for a buffered packet, SEND streams flits.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } inj_state_t;

endpackage

// File: rtl/local_injector_if.sv
// Packet-in / flit-out bundle between the mesh controller, the injector and
// the router local port. The master side is the environment (controller and
// router), the slave side is the injector itself.
interface local_injector_if
  import local_injector_pkg::*;
#(
  parameter int PACKET_SIZE = LI_PACKET_SIZE,
  parameter int FLIT_WIDTH  = LI_FLIT_WIDTH
) ();

  logic                     write_req;
  logic [PACKET_SIZE-1:0]   spike_packet;
  logic                     inj_full;
  logic                     router_full;
  logic [FLIT_WIDTH-1:0]    flit_out;
  logic                     flit_valid;
  logic                     flit_head;
  logic                     flit_tail;
  logic [LI_DROP_WIDTH-1:0] drop_count;

  modport master (
    output write_req, spike_packet, router_full,
    input  inj_full, flit_out, flit_valid, flit_head, flit_tail, drop_count
  );

  modport slave (
    input  write_req, spike_packet, router_full,
    output inj_full, flit_out, flit_valid, flit_head, flit_tail, drop_count
  );

endinterface

// File: rtl/local_injector_packet_fifo.sv
// Show-ahead packet buffer. The head entry is visible on rd_data whenever the
// buffer is non-empty; a pop and a push may share one edge, which lets a
// write land while full as long as the same edge frees a slot.
module packet_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg, count_next;
  logic             full_reg;
  logic             pop_ok, push_ok;

  // A pop is only honoured with data present; a push needs a free slot now
  // or one being released by a pop at the same edge.
  assign pop_ok   = rd_en && (count_reg != '0);
  assign push_ok  = wr_en && (!full_reg || pop_ok);
  assign overflow = wr_en && !push_ok;

  // Occupancy after this edge, also used to register the full flag.
  always_comb begin
    count_next = count_reg + CW'(push_ok) - CW'(pop_ok);
  end

  // Storage array; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == CW'(DEPTH));
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign empty   = (count_reg == '0);
  assign full    = full_reg;

endmodule

// File: rtl/local_injector.sv
// Local injector: buffers spike packets from the mesh controller and
// serializes each one, most significant nibble first, into the router's
// local input port. Back-to-back packets stream without a bubble; the
// router can stall any flit indefinitely.
module local_injector
  import local_injector_pkg::*;
#(
  parameter int PACKET_SIZE = LI_PACKET_SIZE,
  parameter int FLIT_WIDTH  = LI_FLIT_WIDTH,
  parameter int FIFO_DEPTH  = LI_FIFO_DEPTH
) (
  input logic             rt_clk,
  input logic             rt_reset,
  local_injector_if.slave inj
);

  localparam int FLITS = PACKET_SIZE / FLIT_WIDTH;
  localparam int CNT_W = $clog2(FLITS);
  localparam logic [CNT_W-1:0] LAST_FLIT = CNT_W'(FLITS - 1);

  inj_state_t               state_reg, state_next;
  logic [PACKET_SIZE-1:0]   shift_reg, shift_next;
  logic [CNT_W-1:0]         cnt_reg, cnt_next;
  logic [LI_DROP_WIDTH-1:0] drop_count_reg;

  logic                   fifo_pop;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   fifo_overflow;
  logic [PACKET_SIZE-1:0] fifo_head;
  logic                   flit_valid;
  logic                   transfer;

  packet_fifo #(
    .WIDTH (PACKET_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_packet_fifo (
    .clk      (rt_clk),
    .rst      (rt_reset),
    .wr_en    (inj.write_req),
    .wr_data  (inj.spike_packet),
    .rd_en    (fifo_pop),
    .rd_data  (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .overflow (fifo_overflow)
  );

  assign flit_valid = (state_reg == ST_SEND);
  assign transfer   = flit_valid && !inj.router_full;

  // Next-state logic: load from the buffer, shift on each accepted flit and
  // reload directly on the tail so consecutive packets stay contiguous.
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    fifo_pop   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_head;
          cnt_next   = '0;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (transfer) begin
          if (cnt_reg == LAST_FLIT) begin
            cnt_next = '0;
            if (!fifo_empty) begin
              fifo_pop   = 1'b1;
              shift_next = fifo_head;
            end else begin
              shift_next = '0;
              state_next = ST_IDLE;
            end
          end else begin
            shift_next = {shift_reg[PACKET_SIZE-FLIT_WIDTH-1:0], {FLIT_WIDTH{1'b0}}};
            cnt_next   = cnt_reg + CNT_W'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Serializer state register; reset drops any packet in flight.
  always_ff @(posedge rt_clk or posedge rt_reset) begin
    if (rt_reset) begin
      state_reg <= ST_IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Saturating count of packets lost to a full buffer.
  always_ff @(posedge rt_clk or posedge rt_reset) begin
    if (rt_reset) begin
      drop_count_reg <= '0;
    end else if (fifo_overflow && (drop_count_reg != '1)) begin
      drop_count_reg <= drop_count_reg + LI_DROP_WIDTH'(1);
    end
  end

  assign inj.flit_valid = flit_valid;
  assign inj.flit_out   = flit_valid ? shift_reg[PACKET_SIZE-1 -: FLIT_WIDTH] : '0;
  assign inj.flit_head  = flit_valid && (cnt_reg == '0);
  assign inj.flit_tail  = flit_valid && (cnt_reg == LAST_FLIT);
  assign inj.inj_full   = fifo_full;
  assign inj.drop_count = drop_count_reg;

endmodule

// File: tb/tb_local_injector.sv
// Bench for local_injector: directed scenarios (single packet, back-to-back,
// stall, overflow, write-while-full on a tail pop, reset mid-packet) followed
// by randomized bursts checked against an expected flit stream.
module tb_local_injector;

  logic rt_clk;
  logic rt_reset;

  local_injector_if bus ();

  local_injector dut (
    .rt_clk   (rt_clk),
    .rt_reset (rt_reset),
    .inj      (bus)
  );

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [3:0] nib;
    int         idx;
  } flit_t;

  flit_t      exp_q[$];
  bit         mon_en = 0;
  bit         prev_stall = 0;
  logic [3:0] prev_out;
  logic       prev_head, prev_tail;
  int         pkt_done = 0;

  initial rt_clk = 1'b0;
  always #5 rt_clk = ~rt_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [31:0] p, input int k);
    return p[31-4*k -: 4];
  endfunction

  task automatic step();
    @(posedge rt_clk);
    #1;
  endtask

  task automatic expect_flit(input string tag, input logic [3:0] n, input bit h, input bit t);
    check({tag, "_valid"}, 32'(bus.flit_valid), 32'd1);
    check({tag, "_out"},   32'(bus.flit_out),   32'(n));
    check({tag, "_head"},  32'(bus.flit_head),  32'(h));
    check({tag, "_tail"},  32'(bus.flit_tail),  32'(t));
  endtask

  // Stream monitor for the random phase: every accepted flit must be the
  // next nibble of the next accepted packet, and a stalled flit must hold.
  always @(negedge rt_clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        check("rand_hold_out",  32'(bus.flit_out),  32'(prev_out));
        check("rand_hold_head", 32'(bus.flit_head), 32'(prev_head));
        check("rand_hold_tail", 32'(bus.flit_tail), 32'(prev_tail));
      end
      prev_stall = bus.flit_valid && bus.router_full;
      prev_out   = bus.flit_out;
      prev_head  = bus.flit_head;
      prev_tail  = bus.flit_tail;
      if (bus.flit_valid && !bus.router_full) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_flit", 32'd1, 32'd0);
        end else begin
          flit_t e;
          e = exp_q.pop_front();
          check("rand_out",  32'(bus.flit_out),  32'(e.nib));
          check("rand_head", 32'(bus.flit_head), 32'(e.idx == 0));
          check("rand_tail", 32'(bus.flit_tail), 32'(e.idx == 7));
          if (e.idx == 7) begin
            pkt_done++;
            $display("[TB] random packet %0d delivered", pkt_done);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pa, pb, pc;
    logic [31:0] pk[7];
    int          guard;
    int          n;

    rt_reset         = 1'b1;
    bus.write_req    = 1'b0;
    bus.spike_packet = '0;
    bus.router_full  = 1'b0;

    // Outputs under reset
    #2;
    check("rst_valid", 32'(bus.flit_valid), 32'd0);
    check("rst_head",  32'(bus.flit_head),  32'd0);
    check("rst_tail",  32'(bus.flit_tail),  32'd0);
    check("rst_out",   32'(bus.flit_out),   32'd0);
    check("rst_full",  32'(bus.inj_full),   32'd0);
    check("rst_drop",  32'(bus.drop_count), 32'd0);
    step();
    step();
    rt_reset = 1'b0;
    step();
    check("idle_valid", 32'(bus.flit_valid), 32'd0);

    // Single packet: first flit two edges after write_req, 8 flits in a row
    pa = 32'h12345678;
    bus.spike_packet = pa;
    bus.write_req    = 1'b1;
    step();
    bus.write_req = 1'b0;
    check("single_latency_gap", 32'(bus.flit_valid), 32'd0);
    step();
    for (int k = 0; k < 8; k++) begin
      expect_flit("single", nib(pa, k), k == 0, k == 7);
      step();
    end
    check("single_after_valid", 32'(bus.flit_valid), 32'd0);
    $display("[TB] single packet %08h done", pa);

    // Two packets on consecutive cycles: 16 contiguous flits
    pa = 32'hA1B2C3D4;
    pb = 32'h5E6F7089;
    bus.spike_packet = pa;
    bus.write_req    = 1'b1;
    step();
    bus.spike_packet = pb;
    step();
    bus.write_req = 1'b0;
    for (int k = 0; k < 16; k++) begin
      expect_flit("b2b", (k < 8) ? nib(pa, k) : nib(pb, k - 8), (k % 8) == 0, (k % 8) == 7);
      step();
    end
    check("b2b_after_valid", 32'(bus.flit_valid), 32'd0);
    $display("[TB] back-to-back packets %08h %08h done", pa, pb);

    // Stall for 3 cycles while flit 4 is presented
    pa = 32'h12345678;
    bus.spike_packet = pa;
    bus.write_req    = 1'b1;
    step();
    bus.write_req = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      expect_flit("stall_pre", nib(pa, k), k == 0, 1'b0);
      step();
    end
    bus.router_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      expect_flit("stall_hold", 4'h4, 1'b0, 1'b0);
      step();
    end
    bus.router_full = 1'b0;
    for (int k = 3; k < 8; k++) begin
      expect_flit("stall_post", nib(pa, k), 1'b0, k == 7);
      step();
    end
    check("stall_after_valid", 32'(bus.flit_valid), 32'd0);
    $display("[TB] stalled packet %08h done", pa);

    // Overflow: router blocked, 6 writes; 5th fills the buffer, 6th drops
    for (int w = 0; w < 7; w++) pk[w] = 32'h10000000 * (w + 1) + 32'h0123456 * w + 32'h9;
    bus.router_full = 1'b1;
    for (int w = 0; w < 6; w++) begin
      bus.spike_packet = pk[w];
      bus.write_req    = 1'b1;
      step();
      check($sformatf("ovf_full_w%0d", w), 32'(bus.inj_full), 32'(w >= 4));
    end
    bus.write_req = 1'b0;
    check("ovf_drop", 32'(bus.drop_count), 32'd1);
    step();
    check("ovf_stalled_head", 32'(bus.flit_out), 32'(nib(pk[0], 0)));
    bus.router_full = 1'b0;
    // Drain; write while full on the first tail transfer is accepted
    for (int p = 0; p < 6; p++) begin
      pc = (p < 5) ? pk[p] : pk[6];
      for (int k = 0; k < 8; k++) begin
        if (p == 0 && k == 7) begin
          check("wwf_full_before", 32'(bus.inj_full), 32'd1);
          bus.spike_packet = pk[6];
          bus.write_req    = 1'b1;
        end
        expect_flit($sformatf("drain_p%0d", p), nib(pc, k), k == 0, k == 7);
        step();
        bus.write_req = 1'b0;
        if (p == 0 && k == 7) begin
          check("wwf_full_after", 32'(bus.inj_full), 32'd1);
          check("wwf_drop",       32'(bus.drop_count), 32'd1);
        end
      end
      $display("[TB] drained packet %08h", pc);
    end
    check("drain_after_valid", 32'(bus.flit_valid), 32'd0);
    check("drain_after_full",  32'(bus.inj_full),   32'd0);
    check("drain_after_drop",  32'(bus.drop_count), 32'd1);

    // Reset pulsed at flit 3 with a second packet buffered
    pa = 32'hCAFEBABE;
    pb = 32'h0BADF00D;
    bus.spike_packet = pa;
    bus.write_req    = 1'b1;
    step();
    bus.spike_packet = pb;
    step();
    bus.write_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      expect_flit("rstmid_pre", nib(pa, k), k == 0, 1'b0);
      step();
    end
    expect_flit("rstmid_flit3", nib(pa, 2), 1'b0, 1'b0);
    #1;
    rt_reset = 1'b1;
    #1;
    check("rstmid_valid", 32'(bus.flit_valid), 32'd0);
    check("rstmid_out",   32'(bus.flit_out),   32'd0);
    check("rstmid_tail",  32'(bus.flit_tail),  32'd0);
    check("rstmid_drop",  32'(bus.drop_count), 32'd0);
    #1;
    rt_reset = 1'b0;
    step();
    check("rstmid_idle1", 32'(bus.flit_valid), 32'd0);
    step();
    check("rstmid_idle2", 32'(bus.flit_valid), 32'd0);
    pc = 32'h9ABCDEF0;
    bus.spike_packet = pc;
    bus.write_req    = 1'b1;
    step();
    bus.write_req = 1'b0;
    check("rstmid_gap", 32'(bus.flit_valid), 32'd0);
    step();
    for (int k = 0; k < 8; k++) begin
      expect_flit("post_rst", nib(pc, k), k == 0, k == 7);
      step();
    end
    check("post_rst_after_valid", 32'(bus.flit_valid), 32'd0);
    $display("[TB] post-reset packet %08h done", pc);

    // Random bursts of 1..4 packets under random router backpressure
    prev_stall = 0;
    mon_en     = 1;
    for (int b = 0; b < 20; b++) begin
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        flit_t e;
        pa = $urandom;
        for (int k = 0; k < 8; k++) begin
          e.nib = nib(pa, k);
          e.idx = k;
          exp_q.push_back(e);
        end
        bus.spike_packet = pa;
        bus.write_req    = 1'b1;
        bus.router_full  = ($urandom_range(0, 9) < 3);
        step();
      end
      bus.write_req = 1'b0;
      guard = 0;
      while (exp_q.size() != 0 && guard < 400) begin
        bus.router_full = ($urandom_range(0, 9) < 3);
        step();
        guard++;
      end
      check($sformatf("rand_drain_b%0d", b), 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      check($sformatf("rand_idle_b%0d", b), 32'(bus.flit_valid), 32'd0);
    end
    bus.router_full = 1'b0;
    mon_en = 0;
    check("rand_drop", 32'(bus.drop_count), 32'd0);
    check("rand_full", 32'(bus.inj_full),   32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
